// File: rtl/wb_fill_blitter_if.sv
// Single Wishbone classic bus bundle; master drives the request, slave returns data/ack.
// Used both for the CPU-facing register port and the VRAM-facing write port.
interface wb_fill_blitter_if;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        ack;

    modport master (output adr, dat_w, sel, cyc, stb, we, input dat_r, ack);
    modport slave  (input adr, dat_w, sel, cyc, stb, we, output dat_r, ack);
endinterface

// File: rtl/wb_fill_blitter.sv
// Rectangle fill engine: registers over a Wishbone slave, one-word writes on a Wishbone master.
// Slave acks one cycle after strobe; each master beat holds until ack, then idles one cycle.
module wb_fill_blitter #(
    parameter int          STRIDE_BYTES = 320,
    parameter logic [31:0] DEFAULT_BASE = 32'h40100000
) (
    input  logic               clk_100MHz,
    input  logic               rst_n,
    wb_fill_blitter_if.slave   bl_s,
    wb_fill_blitter_if.master  bl,
    output logic               irq
);
    typedef enum logic [1:0] {S_IDLE, S_LINE, S_BEAT, S_NEXT} state_t;

    state_t      state_q, state_d;
    logic [31:0] dst_base_q, line_addr_q, word_addr_q, s_dat_q, rd_mux;
    logic [6:0]  pos_x_q;
    logic [8:0]  pos_y_q;
    logic [7:0]  width_q, words_left_q;
    logic [9:0]  height_q, lines_left_q;
    logic [3:0]  color_q;
    logic        done_q, done_d, aborted_q, aborted_d, irq_en_q, abort_q, s_ack_q, irq_q;

    logic [4:0]  off;
    logic        s_req, s_wr, wr_ctrl, wr_cfg, busy, size_zero;
    logic        start_req, start_go, abort_now, fill_end, done_clr;
    logic        unused_ok;

    assign off       = bl_s.adr[4:0];
    assign s_req     = bl_s.cyc & bl_s.stb & ~s_ack_q;
    assign s_wr      = s_req & bl_s.we;
    assign busy      = (state_q != S_IDLE);
    assign wr_ctrl   = s_wr && (off == 5'h00);
    assign wr_cfg    = s_wr && !busy;
    assign size_zero = (width_q == 8'd0) || (height_q == 10'd0);
    assign start_req = wr_ctrl & bl_s.dat_w[0] & ~busy;
    assign start_go  = start_req & ~size_zero;
    // The abort write itself counts, so a request landing on the NEXT cycle cannot leak one more beat.
    assign abort_now = abort_q | (wr_ctrl & bl_s.dat_w[4] & busy);
    assign done_clr  = wr_ctrl & bl_s.dat_w[2];
    assign unused_ok = ^{bl_s.sel, bl_s.adr[31:5], bl.dat_r};

    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_go) state_d = S_LINE;
            S_LINE: state_d = abort_now ? S_IDLE : S_BEAT;
            S_BEAT: if (bl.ack) state_d = S_NEXT;
            S_NEXT: begin
                if (abort_now)                  state_d = S_IDLE;
                else if (words_left_q > 8'd1)   state_d = S_BEAT;
                else if (lines_left_q > 10'd1)  state_d = S_LINE;
                else                            state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bl.cyc   = (state_q == S_BEAT);
        bl.stb   = bl.cyc;
        bl.we    = bl.cyc;
        bl.sel   = {4{bl.cyc}};
        bl.adr   = word_addr_q;
        bl.dat_w = {8{color_q}};
    end

    assign fill_end = busy && (state_d == S_IDLE);

    always_comb begin
        done_d    = done_q;
        aborted_d = aborted_q;
        if (done_clr) begin
            done_d    = 1'b0;
            aborted_d = 1'b0;
        end
        if (fill_end || (start_req && size_zero)) done_d = 1'b1;
        if (fill_end && abort_now)                aborted_d = 1'b1;
    end

    always_comb begin
        rd_mux = 32'd0;
        case (off)
            5'h00: rd_mux = {26'd0, aborted_q, 1'b0, irq_en_q, done_q, busy, 1'b0};
            5'h04: rd_mux = dst_base_q;
            5'h08: rd_mux = {7'd0, pos_y_q, 9'd0, pos_x_q};
            5'h0C: rd_mux = {6'd0, height_q, 8'd0, width_q};
            5'h10: rd_mux = {28'd0, color_q};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            dst_base_q   <= DEFAULT_BASE;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            width_q      <= '0;
            height_q     <= '0;
            color_q      <= '0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_q      <= 1'b0;
            s_ack_q      <= 1'b0;
            s_dat_q      <= '0;
            irq_q        <= 1'b0;
            line_addr_q  <= '0;
            word_addr_q  <= '0;
            words_left_q <= '0;
            lines_left_q <= '0;
        end else begin
            s_ack_q   <= s_req;
            irq_q     <= done_q & irq_en_q;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            if (s_req) s_dat_q <= rd_mux;
            if (wr_ctrl) irq_en_q <= bl_s.dat_w[3];
            if (wr_cfg) begin
                case (off)
                    5'h04: dst_base_q <= bl_s.dat_w;
                    5'h08: begin
                        pos_x_q <= bl_s.dat_w[6:0];
                        pos_y_q <= bl_s.dat_w[24:16];
                    end
                    5'h0C: begin
                        width_q  <= bl_s.dat_w[7:0];
                        height_q <= bl_s.dat_w[25:16];
                    end
                    5'h10: color_q <= bl_s.dat_w[3:0];
                    default: ;
                endcase
            end
            if (state_d == S_IDLE)                  abort_q <= 1'b0;
            else if (wr_ctrl && bl_s.dat_w[4] && busy) abort_q <= 1'b1;

            case (state_q)
                S_IDLE: if (start_go) begin
                    line_addr_q  <= dst_base_q + 32'(STRIDE_BYTES) * {23'd0, pos_y_q}
                                    + {23'd0, pos_x_q, 2'b00};
                    lines_left_q <= height_q;
                end
                S_LINE: begin
                    word_addr_q  <= line_addr_q;
                    words_left_q <= width_q;
                end
                S_NEXT: begin
                    if (state_d == S_BEAT) begin
                        word_addr_q  <= word_addr_q + 32'd4;
                        words_left_q <= words_left_q - 8'd1;
                    end else if (state_d == S_LINE) begin
                        line_addr_q  <= line_addr_q + 32'(STRIDE_BYTES);
                        lines_left_q <= lines_left_q - 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bl_s.ack   = s_ack_q;
    assign bl_s.dat_r = s_dat_q;
    assign irq        = irq_q;
endmodule

// File: tb/tb_wb_fill_blitter.sv
module tb_wb_fill_blitter;
    logic clk;
    logic rst_n;
    logic irq;

    wb_fill_blitter_if s_bus();
    wb_fill_blitter_if m_bus();

    wb_fill_blitter dut (
        .clk_100MHz (clk),
        .rst_n      (rst_n),
        .bl_s       (s_bus),
        .bl         (m_bus),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;
    int stab_err = 0;
    int ack_lat = 1;
    logic [31:0] beat_adr[$];
    logic [31:0] beat_dat[$];

    typedef struct {
        logic        wr;
        logic [4:0]  off;
        logic [31:0] wdat;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // VRAM-side responder: logs each beat, acks after ack_lat cycles, flags any change while waiting.
    initial begin
        logic [31:0] a, d;
        logic abandoned;
        m_bus.ack   = 1'b0;
        m_bus.dat_r = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (m_bus.cyc === 1'b1 && m_bus.stb === 1'b1) begin
                a = m_bus.adr;
                d = m_bus.dat_w;
                beat_adr.push_back(a);
                beat_dat.push_back(d);
                abandoned = 1'b0;
                for (int k = 1; k < ack_lat; k++) begin
                    @(posedge clk); #1;
                    if (m_bus.cyc !== 1'b1) begin
                        abandoned = 1'b1;
                        break;
                    end
                    if (m_bus.adr !== a || m_bus.dat_w !== d || m_bus.we !== 1'b1 || m_bus.sel !== 4'hF)
                        stab_err++;
                end
                if (!abandoned) begin
                    m_bus.ack = 1'b1;
                    @(posedge clk); #1;
                    m_bus.ack = 1'b0;
                end
            end
        end
    end

    task automatic wb_xfer(input logic we, input logic [4:0] off, input logic [31:0] wd,
                           output logic [31:0] rd);
        int t;
        @(posedge clk); #1;
        s_bus.cyc   = 1'b1;
        s_bus.stb   = 1'b1;
        s_bus.we    = we;
        s_bus.sel   = 4'hF;
        s_bus.adr   = 32'h8000_0000 | {27'd0, off};
        s_bus.dat_w = wd;
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (s_bus.ack !== 1'b1 && t < 20);
        if (s_bus.ack !== 1'b1) check("slave_ack_timeout", 32'd0, 32'd1);
        rd = s_bus.dat_r;
        s_bus.cyc = 1'b0;
        s_bus.stb = 1'b0;
        s_bus.we  = 1'b0;
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] wd);
        logic [31:0] dummy;
        wb_xfer(1'b1, off, wd, dummy);
    endtask

    task automatic rd_check(input string name, input logic [4:0] off, input logic [31:0] exp);
        logic [31:0] r;
        wb_xfer(1'b0, off, 32'd0, r);
        check(name, r, exp);
    endtask

    task automatic wait_done(input int max_polls);
        logic [31:0] r;
        int n;
        n = 0;
        r = 32'd0;
        while (r[2] !== 1'b1 && n < max_polls) begin
            wb_xfer(1'b0, 5'h00, 32'd0, r);
            n++;
        end
        if (r[2] !== 1'b1) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_beats(input int cnt, input int max_cycles);
        int t;
        t = 0;
        while (beat_adr.size() < cnt && t < max_cycles) begin
            @(posedge clk); #1;
            t++;
        end
        if (beat_adr.size() < cnt) check("beat_wait_timeout", beat_adr.size(), cnt);
    endtask

    task automatic check_fill6(input string tag);
        logic [31:0] exp_adr[6];
        exp_adr = '{32'h40100148, 32'h4010014C, 32'h40100150,
                    32'h40100288, 32'h4010028C, 32'h40100290};
        check({tag, "_beat_count"}, beat_adr.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < beat_adr.size()) begin
                check($sformatf("%s_adr%0d", tag, i), beat_adr[i], exp_adr[i]);
                check($sformatf("%s_dat%0d", tag, i), beat_dat[i], 32'hAAAAAAAA);
            end
        end
    endtask

    initial begin
        s_bus.cyc = 1'b0; s_bus.stb = 1'b0; s_bus.we = 1'b0;
        s_bus.sel = 4'h0; s_bus.adr = 32'd0; s_bus.dat_w = 32'd0;

        tbl[0]  = '{1'b0, 5'h04, 32'h0,        32'h40100000};
        tbl[1]  = '{1'b0, 5'h00, 32'h0,        32'h00000000};
        tbl[2]  = '{1'b0, 5'h10, 32'h0,        32'h00000000};
        tbl[3]  = '{1'b1, 5'h08, 32'hFFFFFFFF, 32'h0};
        tbl[4]  = '{1'b0, 5'h08, 32'h0,        32'h01FF007F};
        tbl[5]  = '{1'b1, 5'h0C, 32'hFFFFFFFF, 32'h0};
        tbl[6]  = '{1'b0, 5'h0C, 32'h0,        32'h03FF00FF};
        tbl[7]  = '{1'b1, 5'h10, 32'hFFFFFFFF, 32'h0};
        tbl[8]  = '{1'b0, 5'h10, 32'h0,        32'h0000000F};
        tbl[9]  = '{1'b1, 5'h04, 32'h12345678, 32'h0};
        tbl[10] = '{1'b0, 5'h04, 32'h0,        32'h12345678};
        tbl[11] = '{1'b1, 5'h14, 32'hFFFFFFFF, 32'h0};
        tbl[12] = '{1'b0, 5'h14, 32'h0,        32'h00000000};
        tbl[13] = '{1'b1, 5'h00, 32'h00000008, 32'h0};
        tbl[14] = '{1'b0, 5'h00, 32'h0,        32'h00000008};
        tbl[15] = '{1'b1, 5'h00, 32'h00000000, 32'h0};

        // reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc", {31'd0, m_bus.cyc}, 32'd0);
        check("rst_ack", {31'd0, s_bus.ack}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;

        // register map
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].wr) wr(tbl[i].off, tbl[i].wdat);
            else           rd_check($sformatf("reg_vec%0d", i), tbl[i].off, tbl[i].exp);
        end
        rd_check("ctrl_after_clear", 5'h00, 32'd0);

        // basic fill
        ack_lat = 1;
        wr(5'h04, 32'h40100000);
        wr(5'h08, (32'd1 << 16) | 32'd2);
        wr(5'h0C, (32'd2 << 16) | 32'd3);
        wr(5'h10, 32'hA);
        beat_adr.delete(); beat_dat.delete();
        wr(5'h00, 32'h1);
        wait_done(200);
        repeat (5) @(posedge clk);
        check_fill6("basic");
        rd_check("basic_ctrl", 5'h00, 32'h04);
        wr(5'h00, 32'h04);

        // zero width
        wr(5'h0C, (32'd5 << 16) | 32'd0);
        beat_adr.delete(); beat_dat.delete();
        wr(5'h00, 32'h1);
        repeat (10) @(posedge clk);
        check("zero_no_beats", beat_adr.size(), 32'd0);
        rd_check("zero_ctrl", 5'h00, 32'h04);
        wr(5'h00, 32'h04);

        // wait states, colour freeze, ignored restart
        ack_lat = 4;
        stab_err = 0;
        wr(5'h0C, (32'd2 << 16) | 32'd3);
        beat_adr.delete(); beat_dat.delete();
        wr(5'h00, 32'h1);
        wait_beats(2, 200);
        wr(5'h10, 32'h3);
        wr(5'h00, 32'h1);
        wait_done(300);
        repeat (10) @(posedge clk);
        check_fill6("wait");
        check("wait_stability", stab_err, 32'd0);
        rd_check("wait_color_frozen", 5'h10, 32'hA);
        wr(5'h00, 32'h04);

        // abort during beat 3
        ack_lat = 6;
        wr(5'h0C, (32'd10 << 16) | 32'd10);
        beat_adr.delete(); beat_dat.delete();
        wr(5'h00, 32'h1);
        wait_beats(3, 500);
        wr(5'h00, 32'h10);
        wait_done(200);
        repeat (20) @(posedge clk);
        check("abort_beats", beat_adr.size(), 32'd3);
        rd_check("abort_ctrl", 5'h00, 32'h24);
        wr(5'h00, 32'h04);
        rd_check("abort_cleared", 5'h00, 32'h00);

        // irq
        ack_lat = 1;
        wr(5'h0C, (32'd1 << 16) | 32'd1);
        wr(5'h00, 32'h08);
        wr(5'h00, 32'h09);
        wait_done(100);
        repeat (2) @(posedge clk);
        #1;
        check("irq_set", {31'd0, irq}, 32'd1);
        wr(5'h00, 32'h0C);
        repeat (2) @(posedge clk);
        #1;
        check("irq_clear", {31'd0, irq}, 32'd0);
        wr(5'h00, 32'h00);

        // reset in the middle of a beat
        ack_lat = 20;
        wr(5'h0C, (32'd2 << 16) | 32'd3);
        beat_adr.delete(); beat_dat.delete();
        wr(5'h00, 32'h1);
        wait_beats(1, 200);
        @(posedge clk); #1;
        check("midrst_cyc_before", {31'd0, m_bus.cyc}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_cyc", {31'd0, m_bus.cyc}, 32'd0);
        check("midrst_stb", {31'd0, m_bus.stb}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd_check("midrst_ctrl", 5'h00, 32'h00);
        rd_check("midrst_base", 5'h04, 32'h40100000);
        repeat (30) @(posedge clk);
        #1;
        check("midrst_no_more_beats", beat_adr.size(), 32'd1);
        check("midrst_irq", {31'd0, irq}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
